// File: rtl/rf_pkg.sv
// Types and default sizes shared by the writeback queue and the architectural register file.
package rf_pkg;

  localparam int unsigned DefEntries     = 4;
  localparam int unsigned DefDataBusSize = 8;

  typedef logic [$clog2(DefEntries)-1:0] reg_addr_t;
  typedef logic [DefDataBusSize-1:0]     reg_data_t;

  typedef struct packed {
    reg_addr_t dst;
    reg_data_t data;
  } wb_entry_t;

endpackage

// File: rtl/wb_fwd_mux.sv
// Youngest-match forwarding selector for one read port; entries arrive ordered oldest first.
module wb_fwd_mux #(
  parameter int unsigned addr_width = 2,
  parameter int unsigned data_width = 8,
  parameter int unsigned depth      = 4
) (
  input  logic [addr_width-1:0] src,
  input  logic [data_width-1:0] rf_data,
  input  logic [addr_width-1:0] entry_dst  [depth],
  input  logic [data_width-1:0] entry_data [depth],
  input  logic [depth-1:0]      entry_valid,
  output logic [data_width-1:0] operand,
  output logic                  hit
);

  // Later (younger) matches override earlier ones.
  always_comb begin
    operand = rf_data;
    hit     = 1'b0;
    for (int k = 0; k < int'(depth); k++) begin
      if (entry_valid[k] && (entry_dst[k] == src)) begin
        operand = entry_data[k];
        hit     = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rf_writeback_queue.sv
// In-order writeback buffer: retires one result per cycle into the register file and
// forwards queued, not-yet-written results to the read operands.
module rf_writeback_queue
  import rf_pkg::*;
#(
  parameter int unsigned entries       = DefEntries,
  parameter int unsigned data_bus_size = DefDataBusSize,
  parameter int unsigned read_ports    = 2,
  parameter int unsigned depth         = 4
) (
  input  logic                        clock,
  input  logic                        reset,
  input  logic                        res_valid,
  input  logic [$clog2(entries)-1:0]  res_dst,
  input  logic [data_bus_size-1:0]    res_data,
  output logic                        res_ready,
  input  logic                        wb_hold,
  output logic [$clog2(entries)-1:0]  rf_dst     [1],
  output logic [data_bus_size-1:0]    rf_datain  [1],
  output logic                        rf_wr_en   [1],
  input  logic [$clog2(entries)-1:0]  rd_src     [read_ports],
  input  logic [data_bus_size-1:0]    rf_dataout [read_ports],
  output logic [data_bus_size-1:0]    operand    [read_ports],
  output logic                        fwd_hit    [read_ports],
  output logic [$clog2(depth):0]      occupancy
);

  localparam int unsigned AW = $clog2(entries);
  localparam int unsigned PW = $clog2(depth);
  localparam int unsigned CW = PW + 1;

  logic [AW-1:0]            dst_mem  [depth];
  logic [data_bus_size-1:0] data_mem [depth];
  logic [PW-1:0]            wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]            count_q, count_d;
  logic                     push, pop;

  assign res_ready = (count_q != CW'(depth));
  assign push      = res_valid && res_ready;
  assign pop       = (count_q != '0) && !wb_hold;
  assign occupancy = count_q;

  always_comb begin
    count_d = count_q;
    if (push && !pop) begin
      count_d = count_q + 1'b1;
    end else if (!push && pop) begin
      count_d = count_q - 1'b1;
    end
  end

  // Validity is implied by count; clearing the pointers and count discards every entry.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push) begin
      dst_mem[wr_ptr_q]  <= res_dst;
      data_mem[wr_ptr_q] <= res_data;
    end
  end

  always_comb begin
    rf_wr_en[0]  = pop;
    rf_dst[0]    = pop ? dst_mem[rd_ptr_q] : '0;
    rf_datain[0] = pop ? data_mem[rd_ptr_q] : '0;
  end

  // Queue contents rotated into age order (index 0 = head) for the forwarding muxes.
  logic [AW-1:0]            age_dst   [depth];
  logic [data_bus_size-1:0] age_data  [depth];
  logic [depth-1:0]         age_valid;

  always_comb begin
    for (int k = 0; k < int'(depth); k++) begin
      age_dst[k]   = dst_mem[rd_ptr_q + PW'(k)];
      age_data[k]  = data_mem[rd_ptr_q + PW'(k)];
      age_valid[k] = CW'(k) < count_q;
    end
  end

  for (genvar i = 0; i < int'(read_ports); i++) begin : g_fwd
    wb_fwd_mux #(
      .addr_width (AW),
      .data_width (data_bus_size),
      .depth      (depth)
    ) u_fwd_mux (
      .src         (rd_src[i]),
      .rf_data     (rf_dataout[i]),
      .entry_dst   (age_dst),
      .entry_data  (age_data),
      .entry_valid (age_valid),
      .operand     (operand[i]),
      .hit         (fwd_hit[i])
    );
  end

endmodule

// File: tb/tb_rf_writeback_queue.sv
// Directed bench: expected register-file writes go to a scoreboard queue checked by a monitor.
module tb_rf_writeback_queue;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       res_valid = 1'b0;
  logic [1:0] res_dst = '0;
  logic [7:0] res_data = '0;
  logic       res_ready;
  logic       wb_hold = 1'b0;
  logic [1:0] rf_dst     [1];
  logic [7:0] rf_datain  [1];
  logic       rf_wr_en   [1];
  logic [1:0] rd_src     [2];
  logic [7:0] rf_dataout [2];
  logic [7:0] operand    [2];
  logic       fwd_hit    [2];
  logic [2:0] occupancy;

  int total = 0;
  int bad   = 0;
  logic [9:0] sb_exp [$];

  rf_writeback_queue #(
    .entries       (4),
    .data_bus_size (8),
    .read_ports    (2),
    .depth         (4)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .res_valid  (res_valid),
    .res_dst    (res_dst),
    .res_data   (res_data),
    .res_ready  (res_ready),
    .wb_hold    (wb_hold),
    .rf_dst     (rf_dst),
    .rf_datain  (rf_datain),
    .rf_wr_en   (rf_wr_en),
    .rd_src     (rd_src),
    .rf_dataout (rf_dataout),
    .operand    (operand),
    .fwd_hit    (fwd_hit),
    .occupancy  (occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every register-file write must match the oldest outstanding expectation.
  always @(negedge clock) begin
    if (!reset && rf_wr_en[0] === 1'b1) begin
      if (sb_exp.size() == 0) begin
        check("unexpected_write", {22'd0, rf_dst[0], rf_datain[0]}, 32'hFFFF_FFFF);
      end else begin
        check("rf_write", {22'd0, rf_dst[0], rf_datain[0]}, {22'd0, sb_exp.pop_front()});
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present a result and hold it until accepted; returns the number of edges taken.
  task automatic push(input logic [1:0] d, input logic [7:0] v, output int cycles);
    logic acc;
    res_valid = 1'b1;
    res_dst   = d;
    res_data  = v;
    cycles    = 0;
    acc       = 1'b0;
    while (!acc && cycles < 20) begin
      @(negedge clock);
      acc = res_ready;
      cycles++;
      if (acc) sb_exp.push_back({d, v});
      @(posedge clock);
      #1;
    end
    if (!acc) check("push_timeout", 32'd0, 32'd1);
    res_valid = 1'b0;
  endtask

  task automatic drain();
    int n;
    wb_hold = 1'b0;
    n = 0;
    while (occupancy != 0 && n < 20) begin
      step();
      n++;
    end
    check("drain_occupancy", {29'd0, occupancy}, 32'd0);
    @(negedge clock);
    check("drain_scoreboard_empty", sb_exp.size(), 32'd0);
    step();
  endtask

  initial begin
    int cyc;
    rd_src[0] = 2'd0; rd_src[1] = 2'd0;
    rf_dataout[0] = 8'h33; rf_dataout[1] = 8'h44;
    #12;
    // Reset state
    check("rst_ready", {31'd0, res_ready}, 32'd1);
    check("rst_occupancy", {29'd0, occupancy}, 32'd0);
    check("rst_wr_en", {31'd0, rf_wr_en[0]}, 32'd0);
    check("rst_rf_idle", {22'd0, rf_dst[0], rf_datain[0]}, 32'd0);
    check("rst_fwd_hit", {30'd0, fwd_hit[1], fwd_hit[0]}, 32'd0);
    check("rst_operand0", {24'd0, operand[0]}, 32'h33);
    step();
    reset = 1'b0;
    step();

    // Single push, retired the next cycle
    push(2'd2, 8'h5A, cyc);
    check("single_occupancy", {29'd0, occupancy}, 32'd1);
    check("single_wr_en", {31'd0, rf_wr_en[0]}, 32'd1);
    check("single_rf", {22'd0, rf_dst[0], rf_datain[0]}, {22'd0, 2'd2, 8'h5A});
    step();
    check("single_empty", {29'd0, occupancy}, 32'd0);

    // Forward youngest of two matches
    wb_hold = 1'b1;
    push(2'd1, 8'h11, cyc);
    push(2'd1, 8'h22, cyc);
    rd_src[0] = 2'd1;
    rf_dataout[0] = 8'h00;
    #1;
    check("fwd_operand0", {24'd0, operand[0]}, 32'h22);
    check("fwd_hit0", {31'd0, fwd_hit[0]}, 32'd1);
    check("fwd_hold_wr_en", {31'd0, rf_wr_en[0]}, 32'd0);
    drain();

    // Fill and stall
    wb_hold = 1'b1;
    for (int i = 0; i < 4; i++) push(2'(i), 8'hA0 + 8'(i), cyc);
    check("full_ready", {31'd0, res_ready}, 32'd0);
    check("full_occupancy", {29'd0, occupancy}, 32'd4);
    wb_hold = 1'b0;
    push(2'd0, 8'hA4, cyc);
    check("full_accept_latency", cyc, 32'd2);
    drain();

    // Wrap-around with interleaved holds
    for (int i = 0; i < 10; i++) begin
      wb_hold = (i % 3 == 1);
      push(2'(i % 4), 8'(i), cyc);
    end
    drain();

    // No-hit passthrough, then head forwarding while it is being popped
    wb_hold = 1'b1;
    push(2'd3, 8'h33, cyc);
    rd_src[1] = 2'd0;
    rf_dataout[1] = 8'h7E;
    rd_src[0] = 2'd3;
    rf_dataout[0] = 8'h01;
    #1;
    check("nohit_operand1", {24'd0, operand[1]}, 32'h7E);
    check("nohit_hit1", {31'd0, fwd_hit[1]}, 32'd0);
    check("hit_operand0", {24'd0, operand[0]}, 32'h33);
    wb_hold = 1'b0;
    #1;
    check("pop_head_wr_en", {31'd0, rf_wr_en[0]}, 32'd1);
    check("pop_head_forwarded", {23'd0, fwd_hit[0], operand[0]}, {23'd0, 1'b1, 8'h33});
    step();
    check("after_pop_passthrough", {23'd0, fwd_hit[0], operand[0]}, {23'd0, 1'b0, 8'h01});

    // Async reset mid-queue
    wb_hold = 1'b1;
    for (int i = 0; i < 3; i++) push(2'(i), 8'hC0 + 8'(i), cyc);
    check("midq_occupancy", {29'd0, occupancy}, 32'd3);
    #2;
    reset = 1'b1;
    sb_exp.delete();
    #1;
    check("arst_wr_en", {31'd0, rf_wr_en[0]}, 32'd0);
    check("arst_occupancy", {29'd0, occupancy}, 32'd0);
    check("arst_ready", {31'd0, res_ready}, 32'd1);
    wb_hold = 1'b0;
    step();
    reset = 1'b0;
    for (int i = 0; i < 5; i++) step();
    check("post_reset_occupancy", {29'd0, occupancy}, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

endmodule
